// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two core masters (m0 fetch, m1 load/store) and one memory port.
// The slave modport is the arbiter's view; master is the view of the cores/memory driving it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_addr_ok;
  logic              m0_data_ok;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [MASK_W-1:0] m1_wmask;
  logic              m1_addr_ok;
  logic              m1_data_ok;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  logic              hold_o;
  logic              err_o;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
           mem_addr_ok, mem_data_ok, mem_rdata,
    output m0_addr_ok, m0_data_ok, m0_rdata, m1_addr_ok, m1_data_ok, m1_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, hold_o, err_o
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
           mem_addr_ok, mem_data_ok, mem_rdata,
    input  m0_addr_ok, m0_data_ok, m0_rdata, m1_addr_ok, m1_data_ok, m1_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, hold_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one in-order SRAM-style memory port between fetch (m0) and load/store (m1).
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority, m1 over m0.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MASK_W  = 4,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_ext_i,
  mem_port_arbiter_if.slave bus
);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

  logic               lock_reg;
  logic               lock_id_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [MAX_OUT-1:0] id_fifo_reg;
  logic [MAX_OUT-1:0] fifo_wr_sel;

  logic              gnt_id;
  logic              gnt_req;
  logic              gnt_act;
  logic              mem_req_int;
  logic              accept;
  logic              pop;
  logic              head_id;
  logic              m0_aok;
  logic              m1_aok;
  logic              wr_fields_en;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [MASK_W-1:0] gnt_wmask;
  logic [DATA_W-1:0] rdata_out;

`ifdef ARB_RR_EN
  logic last_id_reg;

  always_ff @(posedge clk or negedge rst_ext_i) begin
    if (!rst_ext_i) begin
      last_id_reg <= 1'b0;
    end else if (accept) begin
      last_id_reg <= gnt_id;
    end
  end
`endif

  // A pending unaccepted request keeps its grant so the address cannot change under the memory.
  always_comb begin
    gnt_id = 1'b0;
    if (lock_reg) begin
      gnt_id = lock_id_reg;
    end else begin
`ifdef ARB_RR_EN
      if (bus.m0_req && bus.m1_req) begin
        gnt_id = ~last_id_reg;
      end else begin
        gnt_id = bus.m1_req;
      end
`else
      gnt_id = bus.m1_req;
`endif
    end
  end

  assign gnt_req     = gnt_id ? bus.m1_req : bus.m0_req;
  assign gnt_act     = rst_ext_i && gnt_req;
  assign mem_req_int = gnt_act && (count_reg != MAX_CNT);
  assign accept      = mem_req_int && bus.mem_addr_ok;
  assign pop         = rst_ext_i && bus.mem_data_ok && (count_reg != '0);
  assign head_id     = id_fifo_reg[rd_ptr_reg];

  assign m0_aok       = accept && !gnt_id;
  assign m1_aok       = accept && gnt_id;
  assign wr_fields_en = gnt_act && gnt_id;
  assign gnt_addr     = gnt_act ? (gnt_id ? bus.m1_addr : bus.m0_addr) : '0;
  assign gnt_wdata    = wr_fields_en ? bus.m1_wdata : '0;
  assign gnt_wmask    = wr_fields_en ? bus.m1_wmask : '0;
  assign rdata_out    = rst_ext_i ? bus.mem_rdata : '0;

  assign bus.mem_req    = mem_req_int;
  assign bus.mem_we     = wr_fields_en && bus.m1_we;
  assign bus.mem_addr   = gnt_addr;
  assign bus.mem_wdata  = gnt_wdata;
  assign bus.mem_wmask  = gnt_wmask;
  assign bus.m0_addr_ok = m0_aok;
  assign bus.m1_addr_ok = m1_aok;
  assign bus.m0_data_ok = pop && !head_id;
  assign bus.m1_data_ok = pop && head_id;
  assign bus.m0_rdata   = rdata_out;
  assign bus.m1_rdata   = rdata_out;
  assign bus.hold_o     = rst_ext_i && ((bus.m0_req && !m0_aok) || (bus.m1_req && !m1_aok));
  assign bus.err_o      = err_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUT; gi++) begin : g_fifo_sel
      assign fifo_wr_sel[gi] = accept && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_ext_i) begin
    if (!rst_ext_i) begin
      id_fifo_reg <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (fifo_wr_sel[i]) begin
          id_fifo_reg[i] <= gnt_id;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ext_i) begin
    if (!rst_ext_i) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= 1'b0;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (accept) begin
        lock_reg <= 1'b0;
      end else if (mem_req_int) begin
        lock_reg    <= 1'b1;
        lock_id_reg <= gnt_id;
      end
      if (accept) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A response with nothing outstanding means the memory side broke ordering.
      if (bus.mem_data_ok && (count_reg == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end
endmodule
